// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: streams round keys 0..10 one per clock and
// keeps all eleven in a store that can be read back with one cycle of latency.
module key_expansion #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clock50MHz,
  input  logic         reset,
  input  logic         startTransition,
  input  logic [127:0] cipherKey,
  input  logic [3:0]   readRound,
  output logic [127:0] roundKey,
  output logic [3:0]   roundNumber,
  output logic         roundKeyValid,
  output logic         keyExpansionDone,
  output logic         busy,
  output logic [127:0] readKey
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] value;
    case (r)
      4'd1:    value = 8'h01;
      4'd2:    value = 8'h02;
      4'd3:    value = 8'h04;
      4'd4:    value = 8'h08;
      4'd5:    value = 8'h10;
      4'd6:    value = 8'h20;
      4'd7:    value = 8'h40;
      4'd8:    value = 8'h80;
      4'd9:    value = 8'h1b;
      4'd10:   value = 8'h36;
      default: value = 8'h00;
    endcase
    return value;
  endfunction

  state_t       state_q, state_d;
  logic         start_prev_q, start_prev_d;
  logic [3:0]   round_cnt_q, round_cnt_d;
  logic [127:0] work_key_q, work_key_d;
  logic [127:0] round_key_q, round_key_d;
  logic [3:0]   round_number_q, round_number_d;
  logic         round_key_valid_q, round_key_valid_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic [127:0] read_key_q, read_key_d;
  logic [127:0] key_store_q [0:NUM_ROUNDS];
  logic [127:0] key_store_d [0:NUM_ROUNDS];

  logic         start_edge;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_word, sub_word, temp_word;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;

  assign start_edge = startTransition & ~start_prev_q;

  // Next round key is derived combinationally from the working key.
  assign {w0, w1, w2, w3} = work_key_q;
  assign rot_word = {w3[23:0], w3[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sub_word
      assign sub_word[gi*8 +: 8] = SBOX[rot_word[gi*8 +: 8]];
    end
  endgenerate

  assign temp_word = sub_word ^ {rcon(round_cnt_q + 4'd1), 24'h000000};
  assign n0        = w0 ^ temp_word;
  assign n1        = w1 ^ n0;
  assign n2        = w2 ^ n1;
  assign n3        = w3 ^ n2;
  assign next_key  = {n0, n1, n2, n3};

  always_comb begin
    state_d           = state_q;
    start_prev_d      = startTransition;
    round_cnt_d       = round_cnt_q;
    work_key_d        = work_key_q;
    round_key_d       = round_key_q;
    round_number_d    = round_number_q;
    round_key_valid_d = 1'b0;
    done_d            = 1'b0;
    busy_d            = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          work_key_d  = cipherKey;
          round_cnt_d = 4'd0;
          state_d     = EXPAND;
        end
      end
      EXPAND: begin
        round_key_d       = work_key_q;
        round_number_d    = round_cnt_q;
        round_key_valid_d = 1'b1;
        busy_d            = 1'b1;
        if (round_cnt_q == LAST_ROUND) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          work_key_d  = next_key;
          round_cnt_d = round_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Store captures the key while it is presented on the streaming outputs.
  always_comb begin
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      key_store_d[i] = key_store_q[i];
      if (round_key_valid_q && (round_number_q == 4'(i))) begin
        key_store_d[i] = round_key_q;
      end
    end
  end

  always_comb begin
    read_key_d = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (readRound == 4'(i)) begin
        read_key_d = key_store_q[i];
      end
    end
  end

  always_ff @(posedge clock50MHz) begin
    if (reset) begin
      state_q           <= IDLE;
      start_prev_q      <= 1'b0;
      round_cnt_q       <= 4'd0;
      work_key_q        <= '0;
      round_key_q       <= '0;
      round_number_q    <= 4'd0;
      round_key_valid_q <= 1'b0;
      done_q            <= 1'b0;
      busy_q            <= 1'b0;
      read_key_q        <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        key_store_q[i] <= '0;
      end
    end else begin
      state_q           <= state_d;
      start_prev_q      <= start_prev_d;
      round_cnt_q       <= round_cnt_d;
      work_key_q        <= work_key_d;
      round_key_q       <= round_key_d;
      round_number_q    <= round_number_d;
      round_key_valid_q <= round_key_valid_d;
      done_q            <= done_d;
      busy_q            <= busy_d;
      read_key_q        <= read_key_d;
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        key_store_q[i] <= key_store_d[i];
      end
    end
  end

  assign roundKey         = round_key_q;
  assign roundNumber      = round_number_q;
  assign roundKeyValid    = round_key_valid_q;
  assign keyExpansionDone = done_q;
  assign busy             = busy_q;
  assign readKey          = read_key_q;

endmodule

// File: doc/key_expansion.md
# key_expansion

Iterative AES-128 key schedule that sits directly upstream of the round datapath. It produces round keys 0–10 from a 128-bit cipher key, one per clock, for add_round_key, whose output feeds sub_byte. It also keeps all eleven keys in an internal store so the round controller can re-read any of them later without re-expanding. SubWord uses four byte S-box lookups with the same byte mapping as sub_byte.

## Interface

Parameters:
- NUM_ROUNDS, 10: last round index; fixed for AES-128, not to be overridden.

Ports:
- clock50MHz  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- startTransition  input  1  start request; a rising edge launches expansion.
- cipherKey  input  128  cipher key; byte 0 is [127:120]; word w0 is [127:96].
- readRound  input  4  index of the stored round key to read back.
- roundKey  output  128  round key currently being streamed.
- roundNumber  output  4  index of roundKey (0–10).
- roundKeyValid  output  1  roundKey/roundNumber valid this cycle.
- keyExpansionDone  output  1  one-cycle pulse, coincident with round 10.
- busy  output  1  expansion in progress.
- readKey  output  128  registered copy of keyStore[readRound].

## Operation

- **FSM states: IDLE, EXPAND.**
  - IDLE → EXPAND on a start edge: startTransition=1 and startPrev=0, where startPrev is a register holding the previous startTransition.
  - EXPAND → IDLE after round 10 is issued.
- **Start edge in IDLE:**
  - cipherKey is captured into the working key register.
  - The round counter is set to 0.
- **Round generation:** in EXPAND, the round r key is computed from the round r-1 key (w0..w3, w0 is MSW):
  - temp = SubWord(RotWord(w3)) ^ {Rcon[r], 24'h0}
  - RotWord({a,b,c,d}) = {b,c,d,a}
  - n0 = w0^temp; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
- **Rcon[1..10]:** 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- **Key store:** every key streamed with roundKeyValid=1 is written to keyStore[roundNumber] in the same cycle (11 × 128 bits).
- **Read port:** each cycle, readKey <= keyStore[readRound]. If readRound > 10, readKey <= 0.
- **Input changes mid-run:**
  - A start edge while busy is ignored; startPrev still updates, so the edge is consumed.
  - cipherKey changes after capture are ignored until the next start.
- **Reset:** all outputs, keyStore, startPrev, the counter and the working key are cleared to 0, and the FSM goes to IDLE.
  - Reset asserted mid-expansion aborts the run. The next run needs a fresh start edge.
  - If startTransition is already high at the first cycle after reset, that counts as an edge.

## Timing

- Start edge sampled at edge T.
- **Edge T+1:**
  - roundKey=cipherKey, roundNumber=0, roundKeyValid=1, busy=1.
- **Edge T+1+r (r = 1..10):** roundKey = round r key, roundNumber = r, roundKeyValid=1.
- **Edge T+11:** keyExpansionDone=1 together with round 10.
- **Edge T+12:** roundKeyValid=0, keyExpansionDone=0, busy=0, FSM in IDLE.
  - roundKey and roundNumber hold the last values (key 10 and 10).
- Latency: 1 cycle from the start edge to key 0; 11 cycles to completion. Streamed keys are strictly consecutive, with no gaps.
- **Read port timing:**
  - 1-cycle latency.
  - A read of index r returns the new key from the cycle after it is written. The read is registered, so a same-cycle read-during-write returns the old contents.
- Back-to-back runs: a new start edge in the cycle after done (T+12 or later) is honoured normally.
- All outputs are 0 out of reset until the first start edge.

## Test plan

- **FIPS-197 vector:** cipherKey=000102030405060708090a0b0c0d0e0f, single start edge.
  - Round 1 = d6aa74fdd2af72fadaa678f1d6ab76fe.
  - Round 10 = 13111d7fe3944a17f307a78b4d2b30c5 at T+11, with keyExpansionDone=1.
  - Exactly 11 valid cycles.
- **Second FIPS-197 vector:** cipherKey=2b7e151628aed2a6abf7158809cf4f3c.
  - Round 0 = cipherKey at T+1.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- **Readback:** after the second vector completes, step readRound through 0..10 and then 15.
  - readKey matches each streamed key one cycle after the index is applied.
  - Index 15 gives 0.
- **Held start:** startTransition held high for 500 cycles, as sub_byte's bench drives it.
  - Exactly one run occurs.
  - A start edge pulsed at T+5 does not restart or perturb the run.
  - Changing cipherKey at T+3 does not alter round keys 3–10.
- **Reset mid-run:** assert reset at T+6 for one cycle.
  - The next cycle has all outputs 0 and busy=0.
  - readKey for index 0 returns 0.
  - A fresh start edge then reproduces the full, correct sequence.
- **Back-to-back:** apply the first key, then a start edge with the second key at T+12.
  - The second run streams its correct keys starting at T+13.
  - keyStore holds the second key set afterwards.
